// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the round datapath blocks.
// Multiples are built only from xtime chains, with no tables and no multipliers.
package aes_pkg;

    localparam int         STATE_W  = 128;
    localparam int         COL_W    = 32;
    localparam int         NUM_COLS = 4;
    localparam logic [7:0] GF_POLY  = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // x8/x4/x2 are the xtime chain; 9, b, d and e are sums of chain terms.
    function automatic logic [7:0] gmul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    // Byte k is the k-th byte from the MSB end; column c holds bytes 4c..4c+3.
    function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] state, input int k);
        return state[STATE_W-1-8*k -: 8];
    endfunction

    function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] state, input int c);
        return state[STATE_W-1-COL_W*c -: COL_W];
    endfunction

endpackage

// File: rtl/mix_columns_if.sv
// Beat interface for the MixColumns stage: input state plus mode in, registered result out.
interface mix_columns_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               inverse;
    logic [STATE_W-1:0] in;
    logic [STATE_W-1:0] out;
    logic               out_valid;

    modport master (output in_valid, output inverse, output in, input out, input out_valid);
    modport slave  (input in_valid, input inverse, input in, output out, output out_valid);

endinterface

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in the MSBs).
module mix_single_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    input  logic             inverse,
    output logic [COL_W-1:0] result
);

    logic [7:0] a [4];

    // Both matrices are circulant, so row r uses the same coefficients on a rotated column.
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [7:0] fwd;
        logic [7:0] inv;

        assign a[r] = col[COL_W-1-8*r -: 8];

        assign fwd = gmul2(a[r]) ^ gmul3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
        assign inv = gmule(a[r]) ^ gmulb(a[(r+1)%4]) ^ gmuld(a[(r+2)%4]) ^ gmul9(a[(r+3)%4]);

        assign result[COL_W-1-8*r -: 8] = inverse ? inv : fwd;
    end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns round stage: four column mixers feeding one register stage.
module mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mix_columns_if.slave bus
);

    logic [STATE_W-1:0] next_state;
    logic [STATE_W-1:0] out_q;
    logic               valid_q;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        mix_single_column u_col (
            .col     (get_col(bus.in, c)),
            .inverse (bus.inverse),
            .result  (next_state[STATE_W-1-COL_W*c -: COL_W])
        );
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so
    // ordering between sequential blocks cannot change behaviour.
    // NOTE: the data register is reset too, so out is never X and reads 0 straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q <= next_state;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: directed vector table, hold/reset sequences, round trip.
module tb_mix_columns;

    typedef struct {
        string        name;
        logic         inverse;
        logic [127:0] in;
        logic [127:0] exp;
    } vec_t;

    localparam int NUM_VECS = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NUM_VECS];

    mix_columns_if bus ();

    mix_columns dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] y;

        vecs[0]  = '{"fips_fwd",   1'b0, 128'h6353e08c0960e104cd70b751bacad0e7, 128'h5f72641557f5bc92f7be3b291db9f91a};
        vecs[1]  = '{"fips_inv",   1'b1, 128'h5f72641557f5bc92f7be3b291db9f91a, 128'h6353e08c0960e104cd70b751bacad0e7};
        vecs[2]  = '{"b2b_fwd_0",  1'b0, 128'ha7be1a6997ad739bd8c9ca451f618b61, 128'hff87968431d86a51645151fa773ad009};
        vecs[3]  = '{"b2b_fwd_1",  1'b0, 128'h3bd92268fc74fb735767cbe0c0590e2d, 128'h4c9c1e66f771f0762c3f868e534df256};
        vecs[4]  = '{"b2b_fwd_2",  1'b0, 128'h2d6d7ef03f33e334093602dd5bfb12c7, 128'h6385b79ffc538df997be478e7547d691};
        vecs[5]  = '{"col_fwd_a",  1'b0, 128'hdb135345f20a225c01010101c6c6c6c6, 128'h8e4da1bc9fdc589d01010101c6c6c6c6};
        vecs[6]  = '{"col_fwd_b",  1'b0, 128'hd4d4d4d52d26314c01010101c6c6c6c6, 128'hd5d5d7d64d7ebdf801010101c6c6c6c6};
        vecs[7]  = '{"zero_inv",   1'b1, 128'h0, 128'h0};
        vecs[8]  = '{"zero_fwd",   1'b0, 128'h0, 128'h0};
        vecs[9]  = '{"equal_inv",  1'b1, 128'h11111111222222229b9b9b9bffffffff, 128'h11111111222222229b9b9b9bffffffff};
        vecs[10] = '{"equal_fwd",  1'b0, 128'h11111111222222229b9b9b9bffffffff, 128'h11111111222222229b9b9b9bffffffff};
        vecs[11] = '{"b2b_inv",    1'b1, 128'hff87968431d86a51645151fa773ad009, 128'ha7be1a6997ad739bd8c9ca451f618b61};

        bus.in_valid = 1'b0;
        bus.inverse  = 1'b0;
        bus.in       = '0;

        #1;
        check("reset_out", bus.out, 128'h0);
        check("reset_valid", {127'h0, bus.out_valid}, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", {127'h0, bus.out_valid}, 128'h0);

        // One beat per cycle; each negedge checks the previous beat, then drives the next.
        for (int i = 0; i <= NUM_VECS; i++) begin
            if (i > 0) begin
                check(vecs[i-1].name, bus.out, vecs[i-1].exp);
                check({vecs[i-1].name, "_valid"}, {127'h0, bus.out_valid}, 128'h1);
            end
            if (i < NUM_VECS) begin
                bus.in_valid = 1'b1;
                bus.inverse  = vecs[i].inverse;
                bus.in       = vecs[i].in;
            end else begin
                bus.in_valid = 1'b0;
                bus.in       = ~vecs[0].in;
            end
            @(negedge clk);
        end

        // Hold: no new beats, out keeps the last result while out_valid stays low.
        for (int i = 0; i < 3; i++) begin
            check("hold_out", bus.out, vecs[NUM_VECS-1].exp);
            check("hold_valid", {127'h0, bus.out_valid}, 128'h0);
            @(negedge clk);
        end

        // Reset asserted between edges with a beat in flight: clears at once, beat is dropped.
        bus.in_valid = 1'b1;
        bus.inverse  = 1'b0;
        bus.in       = vecs[0].in;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", bus.out, 128'h0);
        check("async_rst_valid", {127'h0, bus.out_valid}, 128'h0);
        @(posedge clk);
        #1;
        check("rst_edge_out", bus.out, 128'h0);
        check("rst_edge_valid", {127'h0, bus.out_valid}, 128'h0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out", bus.out, 128'h0);
        check("post_rst_valid", {127'h0, bus.out_valid}, 128'h0);
        bus.in_valid = 1'b1;
        bus.inverse  = 1'b0;
        bus.in       = vecs[0].in;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("post_rst_beat", bus.out, vecs[0].exp);
        check("post_rst_beat_valid", {127'h0, bus.out_valid}, 128'h1);
        @(negedge clk);
        check("post_rst_beat_drop", {127'h0, bus.out_valid}, 128'h0);

        // Round trip: inverse(forward(x)) must return x.
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            bus.in_valid = 1'b1;
            bus.inverse  = 1'b0;
            bus.in       = x;
            @(negedge clk);
            y = bus.out;
            bus.inverse = 1'b1;
            bus.in      = y;
            @(negedge clk);
            check("round_trip", bus.out, x);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
